// File: rtl/minc_loader_if.sv
// Byte-stream receive handshake and program-memory write port of the minc loader.
// The loader takes the slave side; the byte source and memory take the master side.
interface minc_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [9:0] mem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/minc_loader.sv
// Program loader for the minc core: parses SYNC/N/(HI,LO)*N/CK frames, writes
// 10-bit words into program memory and releases the core after a good checksum.
module minc_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] TIMEOUT   = 16'd1000
) (
  input  logic         CLK,
  input  logic         nRESET,
  minc_loader_if.slave bus,
  output logic         cpu_nreset,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    HI    = 3'd2,
    LO    = 3'd3,
    WRITE = 3'd4,
    CHECK = 3'd5,
    RUN   = 3'd6
  } state_t;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  state_t      state_r, state_s;
  logic [7:0]  count_r, count_s;
  logic [7:0]  index_r, index_s;
  logic [7:0]  sum_r, sum_s;
  logic [1:0]  hi_r, hi_s;
  logic [15:0] idle_r, idle_s;
  logic [7:0]  addr_r, addr_s;
  logic [9:0]  wdata_r, wdata_s;
  logic        error_r, error_s;
  logic        mem_we_r;
  logic        cpu_nreset_r;
  logic        busy_r, busy_s;
  logic        done_r;
  logic        accept_s;
  logic        sync_s;
  logic [15:0] idle_inc_s;
  logic        timeout_s;

  assign bus.rx_ready  = (state_r != WRITE);
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign cpu_nreset    = cpu_nreset_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

  assign accept_s   = bus.rx_valid & bus.rx_ready;
  assign sync_s     = accept_s & (bus.rx_data == SYNC_BYTE);
  assign idle_inc_s = idle_r + 16'd1;
  // A zero TIMEOUT disables the abort; the idle counter then just free-runs.
  assign timeout_s  = (TIMEOUT != 16'd0) && (idle_inc_s == TIMEOUT);

  // Next-state and datapath decode for the frame parser.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    index_s = index_r;
    sum_s   = sum_r;
    hi_s    = hi_r;
    idle_s  = idle_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    error_s = error_r;
    case (state_r)
      IDLE: begin
        if (sync_s) begin
          state_s = COUNT;
          error_s = 1'b0;
          sum_s   = 8'd0;
          idle_s  = 16'd0;
        end else begin
          state_s = IDLE;
        end
      end
      COUNT: begin
        if (accept_s) begin
          count_s = bus.rx_data;
          sum_s   = bus.rx_data;
          index_s = 8'd0;
          idle_s  = 16'd0;
          state_s = HI;
        end else if (timeout_s) begin
          state_s = IDLE;
          error_s = 1'b1;
          idle_s  = 16'd0;
        end else begin
          idle_s = idle_inc_s;
        end
      end
      HI: begin
        if (accept_s) begin
          hi_s    = bus.rx_data[1:0];
          sum_s   = sum8(sum_r, bus.rx_data);
          idle_s  = 16'd0;
          state_s = LO;
        end else if (timeout_s) begin
          state_s = IDLE;
          error_s = 1'b1;
          idle_s  = 16'd0;
        end else begin
          idle_s = idle_inc_s;
        end
      end
      LO: begin
        if (accept_s) begin
          wdata_s = {hi_r, bus.rx_data};
          addr_s  = index_r;
          sum_s   = sum8(sum_r, bus.rx_data);
          idle_s  = 16'd0;
          state_s = WRITE;
        end else if (timeout_s) begin
          state_s = IDLE;
          error_s = 1'b1;
          idle_s  = 16'd0;
        end else begin
          idle_s = idle_inc_s;
        end
      end
      WRITE: begin
        // 8-bit compare so that N=0 (256 words) finishes at index 255.
        if (index_r == (count_r - 8'd1)) begin
          state_s = CHECK;
        end else begin
          index_s = index_r + 8'd1;
          state_s = HI;
        end
      end
      CHECK: begin
        if (accept_s) begin
          idle_s = 16'd0;
          if (sum8(sum_r, bus.rx_data) == 8'd0) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
            error_s = 1'b1;
          end
        end else if (timeout_s) begin
          state_s = IDLE;
          error_s = 1'b1;
          idle_s  = 16'd0;
        end else begin
          idle_s = idle_inc_s;
        end
      end
      RUN: begin
        if (sync_s) begin
          state_s = COUNT;
          error_s = 1'b0;
          sum_s   = 8'd0;
          idle_s  = 16'd0;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Frame-in-progress decode of the upcoming state.
  always_comb begin
    busy_s = 1'b0;
    case (state_s)
      COUNT, HI, LO, WRITE, CHECK: busy_s = 1'b1;
      default:                     busy_s = 1'b0;
    endcase
  end

  // Parser state and datapath registers.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r <= IDLE;
      count_r <= 8'd0;
      index_r <= 8'd0;
      sum_r   <= 8'd0;
      hi_r    <= 2'd0;
      idle_r  <= 16'd0;
      addr_r  <= 8'd0;
      wdata_r <= 10'd0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      index_r <= index_s;
      sum_r   <= sum_s;
      hi_r    <= hi_s;
      idle_r  <= idle_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      error_r <= error_s;
    end
  end

  // Registered control outputs, aligned with the state they describe.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      mem_we_r     <= 1'b0;
      cpu_nreset_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      mem_we_r     <= (state_s == WRITE);
      cpu_nreset_r <= (state_s == RUN);
      busy_r       <= busy_s;
      done_r       <= (state_s == RUN);
    end
  end

endmodule

// File: tb/tb_minc_loader.sv
// Self-checking bench for minc_loader: directed frames plus randomized frames
// checked against a frame-level model of the expected writes and outcome.
module tb_minc_loader;
  localparam logic [15:0] TO = 16'd10;

  logic CLK = 1'b0;
  logic nRESET;
  logic cpu_nreset, busy, done, error;
  int   checks = 0;
  int   errors = 0;

  minc_loader_if bus ();

  minc_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .bus        (bus),
    .cpu_nreset (cpu_nreset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 CLK = ~CLK;

  logic [17:0] wlog[$];
  logic [9:0]  mem_obs[256];
  logic [9:0]  mem_exp[256];
  logic [7:0]  hi_a[256];
  logic [7:0]  lo_a[256];

  // Write monitor: one entry per cycle in which mem_we is high.
  always @(negedge CLK) begin
    if (bus.mem_we === 1'b1) begin
      wlog.push_back({bus.mem_addr, bus.mem_wdata});
      mem_obs[bus.mem_addr] = bus.mem_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge CLK);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && guard < 8) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 8) chk("rx_ready_stuck", 32'(bus.rx_ready), 32'd1);
    @(posedge CLK);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Frame model: checksum from the frame rules, expected writes i -> {HI[1:0],LO}.
  task automatic run_frame(input int nw, input logic [7:0] ck_delta, input int gap_max);
    logic [7:0] nb, sum, ck;
    logic       ok;
    nb  = nw[7:0];
    sum = nb;
    for (int i = 0; i < nw; i++) sum = sum + hi_a[i] + lo_a[i];
    ck = 8'd0 - sum + ck_delta;
    ok = (ck_delta == 8'd0);
    wlog.delete();
    send_byte(8'hA5);
    chk("sync_busy", 32'(busy), 32'd1);
    chk("sync_cpu_nreset", 32'(cpu_nreset), 32'd0);
    chk("sync_error", 32'(error), 32'd0);
    send_byte(nb);
    for (int i = 0; i < nw; i++) begin
      idle($urandom_range(gap_max, 0));
      send_byte(hi_a[i]);
      idle($urandom_range(gap_max, 0));
      send_byte(lo_a[i]);
      mem_exp[i] = {hi_a[i][1:0], lo_a[i]};
    end
    idle($urandom_range(gap_max, 0));
    send_byte(ck);
    chk("frame_writes", 32'(wlog.size()), 32'(nw));
    for (int i = 0; i < wlog.size() && i < nw; i++) begin
      chk("write_addr", 32'(wlog[i][17:10]), 32'(i[7:0]));
      chk("write_data", 32'(wlog[i][9:0]), 32'({hi_a[i][1:0], lo_a[i]}));
    end
    chk("end_done", 32'(done), 32'(ok));
    chk("end_cpu_nreset", 32'(cpu_nreset), 32'(ok));
    chk("end_error", 32'(error), 32'(!ok));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_rx_ready", 32'(bus.rx_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] g;
    for (int i = 0; i < 256; i++) begin
      mem_obs[i] = 10'd0;
      mem_exp[i] = 10'd0;
    end
    bus.rx_data  = 8'd0;
    bus.rx_valid = 1'b0;
    nRESET       = 1'b0;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_cpu_nreset", 32'(cpu_nreset), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    nRESET = 1'b1;
    idle(2);

    // A5 02 00 05 01 03 F5
    hi_a[0] = 8'h00; lo_a[0] = 8'h05;
    hi_a[1] = 8'h01; lo_a[1] = 8'h03;
    run_frame(2, 8'h00, 0);
    chk("t1_word0", 32'(wlog[0][9:0]), 32'h005);
    chk("t1_word1", 32'(wlog[1][9:0]), 32'h103);

    // Same frame, CK=F4
    run_frame(2, 8'hFF, 0);
    // Garbage in IDLE, then a good frame
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h12);
    chk("garbage_busy", 32'(busy), 32'd0);
    chk("garbage_error_sticky", 32'(error), 32'd1);
    hi_a[0] = 8'hFE; lo_a[0] = 8'h9C;
    hi_a[1] = 8'h02; lo_a[1] = 8'h41;
    run_frame(2, 8'h00, 1);

    // Timeout boundary: 9 idle cycles tolerated, the 10th aborts
    wlog.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    idle(9);
    chk("to9_error", 32'(error), 32'd0);
    chk("to9_busy", 32'(busy), 32'd1);
    idle(1);
    chk("to10_error", 32'(error), 32'd1);
    chk("to10_busy", 32'(busy), 32'd0);
    chk("to10_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("to10_done", 32'(done), 32'd0);
    chk("to10_no_write", 32'(wlog.size()), 32'd0);

    // N=0: 256 words
    for (int i = 0; i < 256; i++) begin
      hi_a[i] = 8'($urandom);
      lo_a[i] = 8'($urandom);
    end
    run_frame(256, 8'h00, 0);
    chk("n0_last_addr", 32'(wlog[255][17:10]), 32'd255);

    // Reload from RUN, then reset mid-frame
    send_byte(8'hA5);
    chk("reload_cpu_nreset", 32'(cpu_nreset), 32'd0);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_busy", 32'(busy), 32'd1);
    send_byte(8'h03);
    send_byte(8'h7E);
    wlog.delete();
    #3;
    nRESET = 1'b0;
    #1;
    chk("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("mid_rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("mid_rst_cpu_nreset", 32'(cpu_nreset), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    repeat (3) @(negedge CLK);
    nRESET = 1'b1;
    idle(2);
    chk("post_rst_no_write", 32'(wlog.size()), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_cpu_nreset", 32'(cpu_nreset), 32'd0);

    // Randomized frames with garbage prefixes, gaps and corrupted checksums
    for (int f = 0; f < 20; f++) begin
      int nw;
      logic [7:0] delta;
      nw = $urandom_range(8, 1);
      for (int i = 0; i < nw; i++) begin
        hi_a[i] = 8'($urandom);
        lo_a[i] = 8'($urandom);
      end
      delta = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
      end
      run_frame(nw, delta, 3);
    end

    // Memory keeps every word ever written, aborted frames included
    for (int i = 0; i < 256; i++) chk("mem_image", 32'(mem_obs[i]), 32'(mem_exp[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
